// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter scheduler: FSM state encoding,
// default sizes and the pointer-width helper used by the top and the arbiter.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    localparam int DEFAULT_W    = 4;
    localparam int DEFAULT_NREQ = 2;

    // Width of an index into NREQ requesters; never zero, even for NREQ == 1.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_scheduler_if.sv
// Requester-side handshake of the counter scheduler: level requests, packed
// run lengths, and the one-hot grant / done / err / busy status back.
interface counter_scheduler_if #(
    parameter int NREQ = 2,
    parameter int W    = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              busy;

    modport master (output req, len, input grant, done, err, busy);
    modport slave  (input req, len, output grant, done, err, busy);
endinterface

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request after
// ptr, searching cyclically, and returns it one-hot.
module rr_arbiter
    import counter_pkg::*;
#(
    parameter  int NREQ = DEFAULT_NREQ,
    localparam int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            any
);

    // NOTE: every output gets a value before the search loop so no path
    // through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!any && req[PW'((int'(ptr) + i) % NREQ)]) begin
                gnt[PW'((int'(ptr) + i) % NREQ)] = 1'b1;
                any                              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one external up-counter between NREQ requesters: grants round-robin,
// clears the counter, counts to the owner's length, then pulses done.
module counter_scheduler
    import counter_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int W    = DEFAULT_W
) (
    input  logic                clk,
    input  logic                reset,
    counter_scheduler_if.slave  bus,
    output logic                cnt_clr,
    output logic                cnt_en,
    input  logic [W-1:0]        cnt_q
);

    localparam int PW = ptr_width(NREQ);
    // A legal run ends by count 2^W-1; two extra cycles of slack before giving up.
    localparam logic [W+1:0] WD_LIMIT = (W + 2)'((1 << W) + 2);

    state_t          state, state_next;
    logic [PW-1:0]   owner, owner_next;
    logic [PW-1:0]   ptr, ptr_next;
    logic [W-1:0]    len_r, len_r_next;
    logic [W+1:0]    wd, wd_next;
    logic            err_r, err_r_next;

    logic [NREQ-1:0] arb_gnt;
    logic            arb_any;
    logic [PW-1:0]   arb_idx;
    logic [W-1:0]    arb_len;

    logic [NREQ-1:0] grant, done;
    logic            err, busy;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    always_comb begin
        arb_idx = '0;
        arb_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = PW'(i);
                arb_len = bus.len[i*W +: W];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= PW'(NREQ - 1);
            len_r <= '0;
            wd    <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            ptr   <= ptr_next;
            len_r <= len_r_next;
            wd    <= wd_next;
            err_r <= err_r_next;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        len_r_next = len_r;
        wd_next    = wd;
        err_r_next = err_r;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        grant      = '0;
        done       = '0;
        err        = 1'b0;
        busy       = 1'b1;

        unique case (state)
            IDLE: begin
                busy    = 1'b0;
                cnt_clr = 1'b1;
                if (arb_any) begin
                    owner_next = arb_idx;
                    len_r_next = arb_len;
                    wd_next    = '0;
                    err_r_next = 1'b0;
                    state_next = (arb_len == '0) ? DONE : CLEAR;
                end
            end

            CLEAR: begin
                grant[owner] = 1'b1;
                cnt_clr      = 1'b1;
                if (!bus.req[owner]) begin
                    ptr_next   = owner;
                    state_next = IDLE;
                end else begin
                    state_next = RUN;
                end
            end

            RUN: begin
                grant[owner] = 1'b1;
                cnt_en       = (cnt_q != len_r);
                wd_next      = wd + 1'b1;
                // An abort outranks a completion seen in the same cycle.
                if (!bus.req[owner]) begin
                    ptr_next   = owner;
                    state_next = IDLE;
                end else if (cnt_q == len_r) begin
                    state_next = DONE;
                end else if (wd == WD_LIMIT) begin
                    err_r_next = 1'b1;
                    state_next = DONE;
                end
            end

            DONE: begin
                grant[owner] = 1'b1;
                done[owner]  = 1'b1;
                err          = err_r;
                ptr_next     = owner;
                state_next   = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.grant = grant;
    assign bus.done  = done;
    assign bus.err   = err;
    assign bus.busy  = busy;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler with a behavioural shared counter that
// can be forced to stick at 2 to exercise the watchdog.
module tb_counter_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cnt_clr, cnt_en;
    logic [3:0] cnt_q = '0;
    logic       stuck = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cycles;
    int n;

    counter_scheduler_if #(.NREQ(2), .W(4)) bus ();

    counter_scheduler #(.NREQ(2), .W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .cnt_q   (cnt_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stuck)        cnt_q <= 4'd2;
        else if (cnt_clr) cnt_q <= '0;
        else if (cnt_en)  cnt_q <= cnt_q + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_done"},  32'(bus.done),  32'd0);
        check({tag, "_err"},   32'(bus.err),   32'd0);
        check({tag, "_busy"},  32'(bus.busy),  32'd0);
        check({tag, "_clr"},   32'(cnt_clr),   32'd1);
        check({tag, "_en"},    32'(cnt_en),    32'd0);
    endtask

    initial begin
        bus.req = '0;
        bus.len = '0;

        // Reset state
        #2;
        check_reset_values("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single run, len0 = 5: grant at T1, 5 enabled cycles, done at T8
        bus.req = 2'b01;
        bus.len = 8'h05;
        #1;
        check("s1_t0_busy", 32'(bus.busy), 32'd0);
        tick();
        check("s1_t1_grant", 32'(bus.grant), 32'h1);
        check("s1_t1_clr",   32'(cnt_clr),   32'd1);
        en_cycles = 0;
        repeat (6) begin
            tick();
            if (cnt_en) en_cycles++;
        end
        tick();
        check("s1_t8_done", 32'(bus.done), 32'h1);
        check("s1_t8_err",  32'(bus.err),  32'd0);
        check("s1_t8_q",    32'(cnt_q),    32'd5);
        check("s1_en_cyc",  32'(en_cycles), 32'd5);
        bus.req = 2'b00;
        tick();
        check("s1_t9_grant", 32'(bus.grant), 32'd0);
        check("s1_t9_done",  32'(bus.done),  32'd0);

        // Fresh reset so requester 0 wins the contended start
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.req = 2'b11;
        bus.len = 8'h23;
        tick();
        check("s2_t1_grant", 32'(bus.grant), 32'h1);
        repeat (4) tick();
        tick();
        check("s2_t6_done", 32'(bus.done), 32'h1);
        tick();
        check("s2_t7_busy", 32'(bus.busy), 32'd0);
        tick();
        check("s2_t8_grant", 32'(bus.grant), 32'h2);
        repeat (3) tick();
        tick();
        check("s2_t12_done", 32'(bus.done), 32'h2);
        tick();
        tick();
        check("s2_t14_grant", 32'(bus.grant), 32'h1);
        repeat (4) tick();
        tick();
        check("s2_t19_done", 32'(bus.done), 32'h1);
        bus.req = 2'b00;
        tick();
        check("s2_t20_busy", 32'(bus.busy), 32'd0);

        // Zero length: done one cycle after request, counter never enabled
        bus.req = 2'b01;
        bus.len = 8'h00;
        #1;
        check("s3_t0_en", 32'(cnt_en), 32'd0);
        tick();
        check("s3_t1_done",  32'(bus.done),  32'h1);
        check("s3_t1_grant", 32'(bus.grant), 32'h1);
        check("s3_t1_en",    32'(cnt_en),    32'd0);
        bus.req = 2'b00;
        tick();
        check("s3_t2_done", 32'(bus.done), 32'd0);

        // Counter stuck at 2, len0 = 7: watchdog ends the run at T21
        stuck   = 1'b1;
        bus.req = 2'b01;
        bus.len = 8'h07;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (bus.done != 2'b00) break;
        end
        check("s4_wd_cycle", 32'(n),        32'd21);
        check("s4_wd_done",  32'(bus.done), 32'h1);
        check("s4_wd_err",   32'(bus.err),  32'd1);
        bus.req = 2'b00;
        stuck   = 1'b0;
        tick();
        check("s4_idle_busy", 32'(bus.busy), 32'd0);
        check("s4_idle_err",  32'(bus.err),  32'd0);

        // Abort after two RUN cycles, pending requester 1 takes over
        bus.req = 2'b01;
        bus.len = 8'h19;
        tick();
        bus.req = 2'b11;
        tick();
        tick();
        tick();
        bus.req = 2'b10;
        check("s5_t4_done", 32'(bus.done), 32'd0);
        tick();
        check("s5_t5_busy",  32'(bus.busy),  32'd0);
        check("s5_t5_grant", 32'(bus.grant), 32'd0);
        check("s5_t5_done",  32'(bus.done),  32'd0);
        check("s5_t5_err",   32'(bus.err),   32'd0);
        check("s5_t5_clr",   32'(cnt_clr),   32'd1);
        tick();
        check("s5_t6_grant", 32'(bus.grant), 32'h2);
        bus.req = 2'b00;
        tick();
        check("s5_t7_busy", 32'(bus.busy), 32'd0);
        check("s5_t7_done", 32'(bus.done), 32'd0);

        // Reset mid-RUN, then a complete run after release
        bus.req = 2'b01;
        bus.len = 8'h15;
        tick();
        tick();
        tick();
        check("s6_run_en",   32'(cnt_en),   32'd1);
        check("s6_run_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_values("s6_rst");
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("s6_t1_grant", 32'(bus.grant), 32'h1);
        check("s6_t1_q",     32'(cnt_q),     32'd0);
        repeat (6) tick();
        tick();
        check("s6_t8_done", 32'(bus.done), 32'h1);
        check("s6_t8_q",    32'(cnt_q),    32'd5);
        bus.req = 2'b00;
        tick();
        check("s6_end_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
- Shares one external W-bit up-counter (clear, enable, registered count q) between NREQ requesters.
- Each requester asks for a run of LEN counts. The scheduler grants round-robin, clears the counter, enables it until q equals LEN, then pulses done to the owner.
- Sits between the requesting control logic and the shared counter instance. Sole driver of the counter's clear and enable.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 4, counter width and per-requester length width.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- req  input  NREQ  per-requester level request; held until done or abort.
- len  input  NREQ*W  packed run lengths; requester i uses bits [i*W +: W]; sampled only at grant.
- grant  output  NREQ  one-hot owner; all-zero when idle.
- done  output  NREQ  one-cycle pulse to the owner on successful completion.
- err  output  1  one-cycle pulse alongside done when the watchdog fired.
- busy  output  1  high in any state other than IDLE.
- cnt_clr  output  1  synchronous clear to the shared counter.
- cnt_en  output  1  count enable to the shared counter.
- cnt_q  input  W  shared counter value; registered, +1 on each enabled clock.

Behaviour:
- States: IDLE, CLEAR, RUN, DONE; registered state.
- Reset (reset=0, async): IDLE; grant=0, done=0, err=0, busy=0, cnt_en=0, cnt_clr=1; RR pointer = NREQ-1, so requester 0 wins first.
- IDLE:
  - cnt_clr=1, cnt_en=0.
  - If any req: the winner is the first asserted req after the pointer, searching cyclically. Latch owner and len_r from its len field.
  - len_r != 0 -> CLEAR. len_r == 0 -> DONE directly.
- CLEAR: grant[owner]=1, cnt_clr=1, cnt_en=0, for exactly one cycle -> RUN.
- RUN:
  - cnt_clr=0. cnt_en = (cnt_q != len_r), combinational.
  - On cnt_q == len_r -> DONE.
  - Watchdog counter wd (W+2 bits) increments each RUN cycle. If wd reaches 2^W+2 without a match -> DONE with err flagged.
- DONE:
  - grant held, done[owner]=1, err=1 if the watchdog fired, cnt_en=0.
  - Pointer <- owner. -> IDLE.
  - grant drops on the next cycle.
- Latency: req seen in IDLE at T0 -> CLEAR at T1 -> cnt_q=0 at T2 -> cnt_q=N at T(N+2) -> done at T(N+3). For N=0, done at T1.
- Abort: the owner drops req while in CLEAR or RUN -> IDLE next cycle. No done, no err; pointer still advances to owner.
- req from the owner still high in the cycle after done: treated as a new request, subject to round-robin against the others.
- len changes after grant: ignored.
- Reset mid-run: immediate return to IDLE values; cnt_clr=1 clears the counter on the next clock.
- Arithmetic: compare exact W-bit equality. Maximum run is 2^W-1 counts, so the counter never wraps in normal operation.

Decomposition:
- Shared package counter_pkg:
  - state enum {IDLE, CLEAR, RUN, DONE};
  - default W.
- Sub-module rr_arbiter:
  - parameter NREQ; inputs req and pointer; outputs one-hot gnt and any.
  - Combinational, reused by the FSM in IDLE.

Test Plan:
- Reset low for 15, req[0]=1 with len0=5: grant=01 at T1, cnt_en high 5 cycles, done[0] at T8 with cnt_q=5, err=0.
- req=11 simultaneously, len0=3, len1=2: owner 0 first (done at T6). Then owner 1 (grant=10, done[1] 5 cycles after its IDLE). Repeat with both held: owners alternate 0,1,0.
- len0=0 -> done[0] one cycle after req, cnt_en never asserted.
- Counter model stuck at 2 with len0=7: err and done[0] pulse together once wd=18, then back to IDLE.
- req[0] dropped after 2 RUN cycles with len0=9 -> IDLE next cycle, no done, cnt_clr=1; a pending req[1] is granted next.
- reset pulled low mid-RUN: all outputs at reset values immediately; normal operation after release.
